// File: rtl/loproc_rf_arbiter.sv
// Two-port register-file arbiter: the pipeline (port 0) has priority and the debug port (port 1)
// wins one cycle after STARVE_LIMIT consecutive lost cycles. Read data returns one cycle after the grant.
module loproc_rf_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    // Port 0: pipeline
    input  logic                  req0_i,
    input  logic                  we0_i,
    input  logic [ADDR_WIDTH-1:0] ra10_i,
    input  logic [ADDR_WIDTH-1:0] ra20_i,
    input  logic [ADDR_WIDTH-1:0] wa0_i,
    input  logic [DATA_WIDTH-1:0] wd0_i,
    output logic                  gnt0_o,
    output logic                  rvalid0_o,
    output logic [DATA_WIDTH-1:0] rd10_o,
    output logic [DATA_WIDTH-1:0] rd20_o,
    // Port 1: debug
    input  logic                  req1_i,
    input  logic                  we1_i,
    input  logic [ADDR_WIDTH-1:0] ra11_i,
    input  logic [ADDR_WIDTH-1:0] ra21_i,
    input  logic [ADDR_WIDTH-1:0] wa1_i,
    input  logic [DATA_WIDTH-1:0] wd1_i,
    output logic                  gnt1_o,
    output logic                  rvalid1_o,
    output logic [DATA_WIDTH-1:0] rd11_o,
    output logic [DATA_WIDTH-1:0] rd21_o,
    // Register bank side
    output logic                  rb_read_en_o,
    output logic                  rb_write_en_o,
    output logic [ADDR_WIDTH-1:0] rb_addr_src1_o,
    output logic [ADDR_WIDTH-1:0] rb_addr_src2_o,
    output logic [ADDR_WIDTH-1:0] rb_addr_dst_o,
    output logic [DATA_WIDTH-1:0] rb_dst_o,
    input  logic [DATA_WIDTH-1:0] rb_src1_i,
    input  logic [DATA_WIDTH-1:0] rb_src2_i
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_q, starve_d;
    logic       pendValid_q, pendValid_d;
    logic       pendOwner_q, pendOwner_d;
    logic       starveHit;

    // Port 0 wins by default; a starved port 1 takes exactly one cycle once its counter hits the limit.
    always_comb begin
        starveHit = req1_i && (starve_q == LIMIT);
        gnt0_o    = !rst && req0_i && !starveHit;
        gnt1_o    = !rst && req1_i && (!req0_i || starveHit);
    end

    always_comb begin
        rb_read_en_o   = 1'b0;
        rb_write_en_o  = 1'b0;
        rb_addr_src1_o = '0;
        rb_addr_src2_o = '0;
        rb_addr_dst_o  = '0;
        rb_dst_o       = '0;
        if (gnt0_o) begin
            rb_read_en_o   = !we0_i;
            rb_write_en_o  = we0_i;
            rb_addr_src1_o = ra10_i;
            rb_addr_src2_o = ra20_i;
            rb_addr_dst_o  = wa0_i;
            rb_dst_o       = wd0_i;
        end else if (gnt1_o) begin
            rb_read_en_o   = !we1_i;
            rb_write_en_o  = we1_i;
            rb_addr_src1_o = ra11_i;
            rb_addr_src2_o = ra21_i;
            rb_addr_dst_o  = wa1_i;
            rb_dst_o       = wd1_i;
        end
    end

    always_comb begin
        starve_d    = (!req1_i || gnt1_o) ? 4'd0 : starve_q + 4'd1;
        pendValid_d = (gnt0_o && !we0_i) || (gnt1_o && !we1_i);
        pendOwner_d = gnt1_o;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q    <= 4'd0;
            pendValid_q <= 1'b0;
            pendOwner_q <= 1'b0;
        end else begin
            starve_q    <= starve_d;
            pendValid_q <= pendValid_d;
            pendOwner_q <= pendOwner_d;
        end
    end

    // The regbank registers read data on the same edge that loads the pending-read bit.
    always_comb begin
        rvalid0_o = pendValid_q && !pendOwner_q;
        rvalid1_o = pendValid_q && pendOwner_q;
        rd10_o    = rvalid0_o ? rb_src1_i : '0;
        rd20_o    = rvalid0_o ? rb_src2_i : '0;
        rd11_o    = rvalid1_o ? rb_src1_i : '0;
        rd21_o    = rvalid1_o ? rb_src2_i : '0;
    end

endmodule
